// File: rtl/seg7_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter.
// FSM encoding, display data width and default dwell.
package seg7_display_arbiter_pkg;

    localparam int DISP_W          = 32;
    localparam int HOLD_CYCLES_DEF = 25_000_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/seg7_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i
// searching upward from last_id_i+1 with wrap.
module seg7_display_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    elig_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [ID_W-1:0] win_o,
    output logic            found_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(last_id_i) + k) % N);
            if (!found_o && elig_i[idx]) begin
                found_o = 1'b1;
                win_o   = idx;
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display
// between several requesters, with a minimum readable dwell.
module seg7_display_arbiter
    import seg7_display_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_data,
    input  logic                    force_en,
    input  logic [ID_W-1:0]         force_id,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    disp_cs,
    output logic [DISP_W-1:0]       disp_data,
    output logic [ID_W-1:0]         owner,
    output logic                    owner_valid,
    output logic                    busy
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               cs_q, cs_d;
    logic [DISP_W-1:0]  data_q, data_d;
    logic               ov_q, ov_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] elig;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               load, refresh;

    // Shifting past the vector width leaves nothing eligible.
    assign elig = force_en ? (req & (NUM_REQ'(1) << force_id)) : req;

    seg7_display_arbiter_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .elig_i    (elig),
        .last_id_i (last_q),
        .win_o     (win),
        .found_o   (found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = '0;
        cs_d    = 1'b0;
        data_d  = data_q;
        ov_d    = ov_q;
        load    = 1'b0;
        refresh = 1'b0;
        case (state_q)
            ST_IDLE: load = found;
            ST_LOAD: begin
                cnt_d   = CNT_W'(HOLD_CYCLES);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    load = found;
                    if (!found)
                        state_d = ST_IDLE;
                end else if (force_en && found && win != owner_q) begin
                    load = 1'b1;
                end else if (req[owner_q] && gnt_q == '0 &&
                             (!force_en || force_id == owner_q)) begin
                    refresh = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_LOAD;
            gnt_d   = NUM_REQ'(1) << win;
            cs_d    = 1'b1;
            data_d  = req_data[win*DISP_W +: DISP_W];
            owner_d = win;
            last_d  = win;
            ov_d    = 1'b1;
        end
        if (refresh) begin
            gnt_d  = NUM_REQ'(1) << owner_q;
            cs_d   = 1'b1;
            data_d = req_data[owner_q*DISP_W +: DISP_W];
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            cs_q    <= 1'b0;
            data_q  <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign disp_cs     = cs_q;
    assign disp_data   = data_q;
    assign owner       = owner_q;
    assign owner_valid = ov_q;
    assign busy        = busy_q;

endmodule
